// File: rtl/lsu_demux_pkg.sv
// LSU demux shared types: target id encoding and default slave address map.
// Target ids 0..7 name a slave; TGT_ERR names the internal error responder.
package lsu_demux_pkg;

    localparam int TGT_W = 4;

    typedef logic [TGT_W-1:0] tgt_t;

    localparam tgt_t TGT_ERR = tgt_t'(8);

    // Slave 0 sits at 0x1000_xxxx (64 KiB), slave 1 at 0x2000_0xxx (4 KiB).
    localparam logic [63:0] DEF_SLAVE_BASE = {32'h2000_0000, 32'h1000_0000};
    localparam logic [63:0] DEF_SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_0000};

endpackage

// File: rtl/lsu_demux_tag_fifo.sv
// In-order tag FIFO holding the target id of every granted request.
// Ports: clk, rst_n, i_push/i_data, i_pop, o_data (head), o_full, o_empty, o_count.
module lsu_demux_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        // Explicit wrap so non-power-of-two depths work.
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= f_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_inc(r_rd);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

endmodule

// File: rtl/lsu_demux.sv
// LSU request demultiplexer: address-decodes core requests onto N slaves,
// keeps responses in order with a tag FIFO, and stalls on target switches.
// Ports: m_* master request/response, s_* slave channels (addr/we/be/wdata
// broadcast). Define LSU_DEMUX_ERR_EN to answer unmapped addresses with an
// error response; otherwise unmapped addresses go to slave 0.
module lsu_demux
    import lsu_demux_pkg::*;
#(
    parameter int                             N_SLAVES        = 2,
    parameter int                             ADDR_WIDTH      = 32,
    parameter int                             DATA_WIDTH      = 32,
    parameter int                             MAX_OUTSTANDING = 2,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE      = DEF_SLAVE_BASE,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK      = DEF_SLAVE_MASK
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           m_req_i,
    input  logic                           m_we_i,
    input  logic [DATA_WIDTH/8-1:0]        m_be_i,
    input  logic [ADDR_WIDTH-1:0]          m_addr_i,
    input  logic [DATA_WIDTH-1:0]          m_wdata_i,
    output logic                           m_gnt_o,
    output logic                           m_rvalid_o,
    output logic                           m_err_o,
    output logic [DATA_WIDTH-1:0]          m_rdata_o,
    output logic [N_SLAVES-1:0]            s_req_o,
    input  logic [N_SLAVES-1:0]            s_gnt_i,
    input  logic [N_SLAVES-1:0]            s_rvalid_i,
    input  logic [N_SLAVES-1:0]            s_err_i,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata_i,
    output logic [ADDR_WIDTH-1:0]          s_addr_o,
    output logic                           s_we_o,
    output logic [DATA_WIDTH/8-1:0]        s_be_o,
    output logic [DATA_WIDTH-1:0]          s_wdata_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    tgt_t          w_tgt;
    tgt_t          w_head;
    tgt_t          r_last_tgt;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_stall;
    logic          w_fire;
    logic          w_push;

    assign s_addr_o  = m_addr_i;
    assign s_we_o    = m_we_i;
    assign s_be_o    = m_be_i;
    assign s_wdata_o = m_wdata_i;

    // Descending scan so the lowest matching slave index wins.
    always_comb begin
`ifdef LSU_DEMUX_ERR_EN
        w_tgt = TGT_ERR;
`else
        w_tgt = '0;
`endif
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_tgt = tgt_t'(i);
            end
        end
    end

    // Switching targets waits for the FIFO to drain so responses
    // from different slaves can never overtake each other.
    assign w_stall = w_full |
                     ((w_count != '0) & (w_tgt != r_last_tgt));
    assign w_fire  = rst_n & m_req_i & ~w_stall;

    always_comb begin
        s_req_o = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            s_req_o[i] = w_fire & (w_tgt == tgt_t'(i));
        end
    end

    always_comb begin
        m_gnt_o = |(s_gnt_i & s_req_o);
`ifdef LSU_DEMUX_ERR_EN
        if (w_tgt == TGT_ERR) begin
            m_gnt_o = w_fire;
        end
`endif
    end

    assign w_push = m_req_i & m_gnt_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_tgt <= '0;
        end else if (w_push) begin
            r_last_tgt <= w_tgt;
        end
    end

    always_comb begin
        m_rvalid_o = 1'b0;
        m_err_o    = 1'b0;
        m_rdata_o  = '0;
        if (!w_empty) begin
`ifdef LSU_DEMUX_ERR_EN
            // An error tag at the head answers on the cycle it is visible,
            // i.e. the cycle after it was granted.
            if (w_head == TGT_ERR) begin
                m_rvalid_o = 1'b1;
                m_err_o    = 1'b1;
            end
`endif
            for (int i = 0; i < N_SLAVES; i++) begin
                if ((w_head == tgt_t'(i)) && s_rvalid_i[i]) begin
                    m_rvalid_o = 1'b1;
                    m_err_o    = s_err_i[i];
                    m_rdata_o  = s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    lsu_demux_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TGT_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_tgt),
        .i_pop   (m_rvalid_o),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
